// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with row synchronizer, press/release
// debounce and a registered key code with a one-cycle valid pulse.
//
// Ports:
//   clk        in   system clock (1.5 MHz)
//   reset      in   asynchronous active-low reset
//   rows[3:0]  in   keypad rows, active-low, asynchronous to clk
//   cols[3:0]  out  keypad columns, active-low, exactly one bit low
//   key[3:0]   out  code of the last accepted key
//   key_valid  out  one-cycle pulse when a press is accepted
//   key_held   out  high while the accepted key is still down
//
// Build option: define KEYPAD_HEX_MAP_EN to report the printed hex legend of the
// key instead of the raw {row, col} code.
module keypad_scanner #(
    parameter int SCAN_DIV        = 1500,
    parameter int DEBOUNCE_CYCLES = 30000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);
    localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0] S_SCAN = 2'd0, S_DEBOUNCE = 2'd1, S_HELD = 2'd2, S_RELEASE = 2'd3;
`ifdef KEYPAD_HEX_MAP_EN
    // nibble {row, col} holds the legend printed on that key
    localparam logic [63:0] HEX_MAP = 64'hDEF0_C987_B654_A321;
`endif

    logic [3:0]    r_sync1, r_sync2;
    logic [1:0]    r_state, r_col, r_row;
    logic [CW-1:0] r_cnt;
    logic [1:0]    w_first_row;
    logic          w_row_low, w_any_low, w_scan_end, w_db_end;
    logic [3:0]    w_key_code, w_next_cols;

    assign w_any_low   = r_sync2 != 4'hF;
    // lowest-index low row wins when several keys share the column
    assign w_first_row = !r_sync2[0] ? 2'd0 : !r_sync2[1] ? 2'd1 : !r_sync2[2] ? 2'd2 : 2'd3;
    assign w_row_low   = !r_sync2[r_row];
    assign w_scan_end  = r_cnt == SCAN_LAST;
    assign w_db_end    = r_cnt == DB_LAST;
    assign w_next_cols = {cols[2:0], cols[3]};
`ifdef KEYPAD_HEX_MAP_EN
    assign w_key_code  = HEX_MAP[{r_row, r_col, 2'b00} +: 4];
`else
    assign w_key_code  = {r_row, r_col};
`endif

    always_ff @(posedge clk or negedge reset)
        if (!reset) {r_sync2, r_sync1} <= 8'hFF;
        else {r_sync2, r_sync1} <= {r_sync1, rows};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_SCAN;
            r_cnt     <= '0;
            r_col     <= 2'd0;
            r_row     <= 2'd0;
            cols      <= 4'b1110;
            key       <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (r_state)
                S_SCAN:
                    if (!w_scan_end) r_cnt <= r_cnt + CW'(1);
                    else begin
                        r_cnt <= '0;
                        if (w_any_low) begin
                            r_row   <= w_first_row;
                            r_state <= S_DEBOUNCE;
                        end else begin
                            r_col <= r_col + 2'd1;
                            cols  <= w_next_cols;
                        end
                    end
                S_DEBOUNCE:
                    if (!w_row_low) begin
                        r_state <= S_SCAN;
                        r_cnt   <= '0;
                        r_col   <= r_col + 2'd1;
                        cols    <= w_next_cols;
                    end else if (w_db_end) begin
                        r_state   <= S_HELD;
                        r_cnt     <= '0;
                        key       <= w_key_code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else r_cnt <= r_cnt + CW'(1);
                S_HELD:
                    if (!w_row_low) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= '0;
                    end
                S_RELEASE:
                    if (w_row_low) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else if (w_db_end) begin
                        r_state  <= S_SCAN;
                        r_cnt    <= '0;
                        r_col    <= r_col + 2'd1;
                        cols     <= w_next_cols;
                        key_held <= 1'b0;
                    end else r_cnt <= r_cnt + CW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
// A small keypad model pulls a row low when a pressed key's column is driven.
// Cycle N counts negedges after reset release; checks are taken at negedges.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  rows, cols, key;
    logic        key_valid, key_held;
    logic [15:0] pressed = '0;
    int          tests = 0, fails = 0, cyc = 0;
`ifdef KEYPAD_HEX_MAP_EN
    localparam logic [3:0] K9 = 4'h8;
`else
    localparam logic [3:0] K9 = 4'h9;
`endif
    localparam logic [3:0] K4 = 4'h4;

    always #5 clk = ~clk;

    always_comb for (int r = 0; r < 4; r++) rows[r] = ~|(pressed[r*4 +: 4] & ~cols);

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .key(key), .key_valid(key_valid), .key_held(key_held)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic at(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic press(input int r, input int c);
        pressed[r*4 + c] = 1'b1;
    endtask

    function automatic logic [3:0] colpat(input int i);
        return ~(4'b0001 << i);
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cols", cols, 4'b1110);
        chk("rst_key", key, 4'h0);
        chk("rst_kv", {3'b0, key_valid}, 4'd0);
        chk("rst_kh", {3'b0, key_held}, 4'd0);
        reset = 1'b1;
        // 1: idle scan
        for (int k = 0; k <= 16; k++) begin
            at(k);
            chk("idle_cols", cols, colpat((k / 4) % 4));
            chk("idle_kv", {3'b0, key_valid}, 4'd0);
        end
        // 2: key (row2,col1); found at end of col1 dwell, pulse 8 cycles later
        press(2, 1);
        at(31);
        chk("p1_kv_early", {3'b0, key_valid}, 4'd0);
        chk("p1_kh_early", {3'b0, key_held}, 4'd0);
        at(32);
        chk("p1_kv", {3'b0, key_valid}, 4'd1);
        chk("p1_key", key, K9);
        chk("p1_kh", {3'b0, key_held}, 4'd1);
        at(33);
        chk("p1_kv_once", {3'b0, key_valid}, 4'd0);
        chk("p1_cols_hold", cols, 4'b1101);
        for (int k = 34; k <= 55; k++) begin
            at(k);
            chk("p1_no_repeat", {3'b0, key_valid}, 4'd0);
            chk("p1_kh_hold", {3'b0, key_held}, 4'd1);
        end
        // 4: 2-cycle glitch during HELD must not release or re-pulse
        for (int k = 56; k <= 65; k++) begin
            at(k);
            if (k == 56) pressed = '0;
            if (k == 58) press(2, 1);
            chk("glitch_kh", {3'b0, key_held}, 4'd1);
            chk("glitch_kv", {3'b0, key_valid}, 4'd0);
        end
        at(66);
        pressed = '0;
        at(76);
        chk("rel1_kh_late", {3'b0, key_held}, 4'd1);
        at(77);
        chk("rel1_kh", {3'b0, key_held}, 4'd0);
        chk("rel1_cols", cols, 4'b1011);
        press(2, 1);
        at(100);
        chk("p2_kv_early", {3'b0, key_valid}, 4'd0);
        at(101);
        chk("p2_kv", {3'b0, key_valid}, 4'd1);
        chk("p2_key", key, K9);
        pressed = '0;
        at(111);
        chk("rel2_kh_late", {3'b0, key_held}, 4'd1);
        at(112);
        chk("rel2_kh", {3'b0, key_held}, 4'd0);
        chk("rel2_cols", cols, 4'b1011);
        // 3: 3-cycle bounce in col1 -> back to scanning at col2, no pulse
        at(124);
        chk("b_cols_start", cols, 4'b1101);
        press(2, 1);
        for (int k = 125; k <= 134; k++) begin
            at(k);
            if (k == 127) pressed = '0;
            chk("b_kv", {3'b0, key_valid}, 4'd0);
        end
        at(134);
        chk("b_cols_scan", cols, 4'b0111);
        chk("b_key_stable", key, K9);
        // 5: rows 1 and 3 low in col0 -> row 1 reported
        press(1, 0);
        press(3, 0);
        at(149);
        chk("m_kv_early", {3'b0, key_valid}, 4'd0);
        at(150);
        chk("m_kv", {3'b0, key_valid}, 4'd1);
        chk("m_key", key, K4);
        chk("m_kh", {3'b0, key_held}, 4'd1);
        pressed = '0;
        at(160);
        chk("m_kh_late", {3'b0, key_held}, 4'd1);
        at(161);
        chk("m_kh_drop", {3'b0, key_held}, 4'd0);
        chk("m_cols", cols, 4'b1101);
        // 6: reset in the middle of DEBOUNCE
        press(0, 1);
        at(168);
        chk("r_cols_pre", cols, 4'b1101);
        reset = 1'b0;
        #1;
        chk("r_cols", cols, 4'b1110);
        chk("r_key", key, 4'h0);
        chk("r_kv", {3'b0, key_valid}, 4'd0);
        chk("r_kh", {3'b0, key_held}, 4'd0);
        pressed = '0;
        at(170);
        reset = 1'b1;
        for (int k = 171; k <= 200; k++) begin
            at(k);
            chk("r_no_pulse", {3'b0, key_valid}, 4'd0);
            chk("r_key_zero", key, 4'h0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
